// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
//   Shared types and default constants for the prog_clk_div divider.
//   - CLKDIV_CNT_W   : default counter/config width in bits.
//   - CLKDIV_DEF_TC  : reset terminal count (period = DEF_TC+1 cycles).
//   - CLKDIV_DEF_LOW : reset low-phase length.
//   - cfg_t          : one channel configuration {tc, low}.
//   cfg_t fields are CLKDIV_CNT_W wide. Narrower CNT_W values are
//   zero-extended into them, so CNT_W must not exceed CLKDIV_CNT_W.
// ---------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W   = 30;
  localparam int CLKDIV_DEF_TC  = 49999999;
  localparam int CLKDIV_DEF_LOW = 25000000;

  typedef struct packed {
    logic [CLKDIV_CNT_W-1:0] tc;   // terminal count: the channel wraps when cnt == tc
    logic [CLKDIV_CNT_W-1:0] low;  // q stays low while cnt < low
  } cfg_t;

endpackage

// File: rtl/clkdiv_chan.sv
// ---------------------------------------------------------------------------
// clkdiv_chan
//   One divider channel. It holds the free-running counter, the active and
//   shadow configuration, the pending flag and the divided output.
//   Optional macro CLKDIV_TICK_EN adds a registered wrap strobe (tick_o).
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   en_i    in   run enable (0 = IDLE, 1 = RUN)
//   sync_i  in   phase restart (cnt <= 0 on the next edge)
//   wr_i    in   config write accepted for this channel this cycle
//   cfg_i   in   new {tc, low} to place in the shadow register
//   pend_o  out  shadow holds a config that has not been applied yet
//   q_o     out  divided output, (cnt >= low) while running
//   tick_o  out  one-cycle pulse after a wrap or sync in RUN (CLKDIV_TICK_EN)
// ---------------------------------------------------------------------------
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CLKDIV_CNT_W,
  parameter int DEF_TC  = CLKDIV_DEF_TC,
  parameter int DEF_LOW = CLKDIV_DEF_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic sync_i,
  input  logic wr_i,
  input  cfg_t cfg_i,
  output logic pend_o,
  output logic q_o
`ifdef CLKDIV_TICK_EN
  ,
  output logic tick_o
`endif
);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  cfg_t                    act_q, act_d;
  cfg_t                    shd_q, shd_d;
  logic                    pend_q, pend_d;
  logic [CLKDIV_CNT_W-1:0] cnt_ext;
  logic                    restart;

  assign cnt_ext = CLKDIV_CNT_W'(cnt_q);

  // A sync and a wrap in the same cycle have the same effect (cnt <= 0,
  // pending applied), so one restart term covers both.
  assign restart = en_i && (sync_i || (cnt_ext == act_q.tc));

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;

    if (!en_i || restart) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // An IDLE channel applies its pending config straight away. A running
    // channel applies it only at a restart.
    if (pend_q && (!en_i || restart)) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    // A write is only accepted while pend_q is clear, so it never coincides
    // with an apply. A write that lands on a wrap therefore waits for the
    // following wrap.
    if (wr_i) begin
      shd_d  = cfg_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= '{tc: CLKDIV_CNT_W'(DEF_TC), low: CLKDIV_CNT_W'(DEF_LOW)};
      shd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  // Compare of registered values, so there is no added latency. The enable
  // gate forces q low as soon as the channel drops to IDLE.
  assign q_o    = en_i && (cnt_ext >= act_q.low);

`ifdef CLKDIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= restart;
    end
  end

  assign tick_o = tick_q;
`endif

endmodule

// File: rtl/prog_clk_div.sv
// ---------------------------------------------------------------------------
// prog_clk_div
//   Multi-channel programmable clock/pulse divider. Each channel produces a
//   square/PWM output whose period (tc+1) and low phase (low) are loaded at
//   runtime through a valid/ready write port. New settings take effect
//   glitch-free at the channel's next wrap, or at the next sync.
//   Optional macro CLKDIV_TICK_EN adds the per-channel tick output.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   ch_en      in   [NCH] per-channel run enable
//   sync       in   synchronous phase restart of all running channels
//   cfg_valid  in   config write request
//   cfg_ready  out  config write can be accepted
//   cfg_ch     in   [CH_W] target channel; writes to cfg_ch >= NCH are dropped
//   cfg_tc     in   [CNT_W] new terminal count
//   cfg_low    in   [CNT_W] new low-phase length
//   q          out  [NCH] divided outputs
//   tick       out  [NCH] wrap strobes (CLKDIV_TICK_EN only)
// ---------------------------------------------------------------------------
module prog_clk_div
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int CNT_W   = CLKDIV_CNT_W,
  parameter int DEF_TC  = CLKDIV_DEF_TC,
  parameter int DEF_LOW = CLKDIV_DEF_LOW,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_tc,
  input  logic [CNT_W-1:0] cfg_low,
  output logic [NCH-1:0]   q
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NCH-1:0]   tick
`endif
);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;
  cfg_t           cfg_w;

  assign cfg_w.tc  = CLKDIV_CNT_W'(cfg_tc);
  assign cfg_w.low = CLKDIV_CNT_W'(cfg_low);

  // Ready reflects only the addressed channel's pending flag. A cfg_ch that
  // matches no channel keeps ready high, so those writes are accepted and
  // dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend[i];
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign wr[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DEF_TC  (DEF_TC),
      .DEF_LOW (DEF_LOW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en_i   (ch_en[gi]),
      .sync_i (sync),
      .wr_i   (wr[gi]),
      .cfg_i  (cfg_w),
      .pend_o (pend[gi]),
      .q_o    (q[gi])
`ifdef CLKDIV_TICK_EN
      ,
      .tick_o (tick[gi])
`endif
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div. The stimulus process pushes the
// expected q / cfg_ready (/ tick) values for the current cycle into a queue.
// The monitor pops and compares them on the falling edge. Channel phase
// origins, periods and low lengths are hand-placed at the cycle where each
// configuration takes effect.
module tb_prog_clk_div;

  localparam int NCH   = 8;
  localparam int CNT_W = 30;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   ch_en;
  logic             sync;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_tc;
  logic [CNT_W-1:0] cfg_low;
  logic [NCH-1:0]   q;
`ifdef CLKDIV_TICK_EN
  logic [NCH-1:0]   tick;
`endif

  always #5 clk = ~clk;

  prog_clk_div #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .DEF_TC  (9),
    .DEF_LOW (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_en     (ch_en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_tc    (cfg_tc),
    .cfg_low   (cfg_low),
    .q         (q)
`ifdef CLKDIV_TICK_EN
    ,
    .tick      (tick)
`endif
  );

  // kind: 0 = q vector, 1 = cfg_ready, 2 = tick vector
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   k      = 0;

  // Expected-behaviour bookkeeping per channel: the cycle where cnt was 0,
  // the period, the low length, the enable, and whether that origin came
  // from a wrap/sync (which produces a tick).
  int org  [NCH];
  int per  [NCH];
  int lowv [NCH];
  bit en_m [NCH];
  bit otick[NCH];

  chk_t        mon_c;
  logic [31:0] mon_act;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_c = sb.pop_front();
      case (mon_c.kind)
        0:       mon_act = 32'(q);
        1:       mon_act = 32'(cfg_ready);
`ifdef CLKDIV_TICK_EN
        2:       mon_act = 32'(tick);
`endif
        default: mon_act = '0;
      endcase
      n_chk++;
      if (mon_act === mon_c.exp) n_pass++;
      else $display("FAIL %s at k=%0d: got %h, expected %h", mon_c.name, k, mon_act, mon_c.exp);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic push(int kind, logic [31:0] e, string nm);
    chk_t c;
    c.kind = kind;
    c.exp  = e;
    c.name = nm;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] exp_q();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      if (en_m[i] && (((k - org[i]) % per[i]) >= lowv[i])) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] exp_tick();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      if (en_m[i] && ((k == org[i] && otick[i]) || (k > org[i] && ((k - org[i]) % per[i]) == 0)))
        v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_defaults();
    for (int i = 0; i < NCH; i++) begin
      org[i] = 0; per[i] = 10; lowv[i] = 5; en_m[i] = 1'b1; otick[i] = 1'b0;
    end
  endtask

  task automatic upd(int ch, int o, int p, int l, bit t);
    org[ch] = o; per[ch] = p; lowv[ch] = l; otick[ch] = t;
  endtask

  task automatic step();
    push(0, exp_q(), "q");
`ifdef CLKDIV_TICK_EN
    push(2, exp_tick(), "tick");
`endif
    @(posedge clk); #1;
    k++;
  endtask

  task automatic run_to(int n);
    while (k < n) step();
  endtask

  task automatic wr(int ch, int tc, int low);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_tc    = CNT_W'(tc);
    cfg_low   = CNT_W'(low);
    $display("cfg write ch%0d tc=%0d low=%0d at k=%0d", ch, tc, low, k);
  endtask

  task automatic reset_checks(string tag);
    push(1, 32'd1, {"ready_", tag});
    push(0, 32'd0, {"q_", tag});
`ifdef CLKDIV_TICK_EN
    push(2, 32'd0, {"tick_", tag});
`endif
  endtask

  initial begin
    reset = 1'b1; ch_en = '1; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_tc = '0; cfg_low = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    k = 0;
    model_defaults();
    push(1, 32'd1, "ready_after_reset");
    run_to(23);

    // ch2 tc=3 low=2 written mid-period; stays pending until ch2 wraps.
    wr(2, 3, 2);
    push(1, 32'd1, "ready_ch2_wr");
    step();
    cfg_valid = 1'b0;
    while (k < 30) begin
      push(1, 32'd0, "ready_ch2_pending");
      step();
    end
    upd(2, 30, 4, 2, 1'b1);
    push(1, 32'd1, "ready_ch2_applied");
    run_to(38);

    // Boundary configs: low=0, low>tc, tc=0. The ch1 write lands on a wrap.
    wr(0, 9, 0);  push(1, 32'd1, "ready_ch0"); step();
    wr(1, 9, 12); push(1, 32'd1, "ready_ch1"); step();
    upd(0, 40, 10, 0, 1'b1);
    wr(3, 0, 0);  push(1, 32'd1, "ready_ch3"); step();
    cfg_valid = 1'b0;
    run_to(45);
    cfg_ch = 3'd1;
    push(1, 32'd0, "ready_ch1_wait_next_wrap");
    run_to(50);
    upd(1, 50, 10, 12, 1'b1);
    upd(3, 50, 1, 0, 1'b1);
    push(1, 32'd1, "ready_ch1_applied");
    run_to(60);

    // Second write to ch2 held while pending, then ch5 accepted.
    wr(2, 5, 3); push(1, 32'd1, "ready_ch2_a"); step();
    wr(2, 7, 4); push(1, 32'd0, "ready_ch2_b_held"); step();
    upd(2, 62, 6, 3, 1'b1);
    push(1, 32'd1, "ready_ch2_b_accept"); step();
    wr(5, 4, 1); push(1, 32'd1, "ready_ch5"); step();
    cfg_valid = 1'b0;
    cfg_ch = 3'd2;
    while (k < 68) begin
      push(1, 32'd0, "ready_ch2_b_pending");
      step();
    end
    upd(2, 68, 8, 4, 1'b1);
    push(1, 32'd1, "ready_ch2_b_applied");
    run_to(70);
    upd(5, 70, 5, 1, 1'b1);
    step();

    // ch4 pending at sync applies on the sync edge; ch6 accepted with sync stays pending.
    wr(4, 6, 2); push(1, 32'd1, "ready_ch4"); step();
    cfg_valid = 1'b0;
    cfg_ch = 3'd4;
    push(1, 32'd0, "ready_ch4_pending"); step();
    sync = 1'b1;
    wr(6, 9, 3); push(1, 32'd1, "ready_ch6_with_sync"); step();
    sync = 1'b0;
    cfg_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      org[i] = 74; otick[i] = 1'b1;
    end
    per[4] = 7; lowv[4] = 2;
    cfg_ch = 3'd6;
    push(1, 32'd0, "ready_ch6_still_pending"); step();
    cfg_ch = 3'd4;
    push(1, 32'd1, "ready_ch4_applied_by_sync");
    run_to(84);
    upd(6, 84, 10, 3, 1'b1);
    cfg_ch = 3'd6;
    push(1, 32'd1, "ready_ch6_applied");
    run_to(88);

    // ch6 IDLE for four cycles, then restarts from cnt=0.
    ch_en[6] = 1'b0; en_m[6] = 1'b0;
    run_to(92);
    ch_en[6] = 1'b1; en_m[6] = 1'b1;
    upd(6, 92, 10, 3, 1'b0);
    run_to(101);

    // A pending ch7 write is lost in a mid-run reset.
    wr(7, 2, 1); push(1, 32'd1, "ready_ch7"); step();
    cfg_valid = 1'b0;
    push(1, 32'd0, "ready_ch7_pending"); step();
    reset = 1'b1;
    reset_checks("mid_run");
    @(posedge clk); #1;
    reset_checks("mid_run_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    k = 0;
    model_defaults();
    push(1, 32'd1, "ready_ch7_cleared");
    run_to(15);

    @(posedge clk); #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d checks left unconsumed, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
